// File: rtl/pipeline_rx.sv
// Receive-side FIFO for a stall-free valid pipeline. It returns one credit per drained entry.
// Define PIPELINE_RX_PARITY_EN to add even-parity checking (parity_in / parity_err).
module pipeline_rx #(
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_in,
    input  logic [DW-1:0] data_in,
`ifdef PIPELINE_RX_PARITY_EN
    input  logic          parity_in,
    output logic          parity_err,
`endif
    output logic          valid_out,
    output logic [DW-1:0] data_out,
    input  logic          ready_in,
    output logic          credit_out,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          credit_q, overflow_q;
    logic          push, pop;

    // When the FIFO is full, a beat is still accepted if the head leaves in the same cycle.
    assign pop  = (count_q != '0) & ready_in;
    assign push = valid_in & ((count_q != FULL) | pop);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q  <= count_d;
            credit_q <= pop;
            if (valid_in & ~push) overflow_q <= 1'b1;
        end
    end

    // Storage has no reset; the count gates visibility of its contents.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

`ifdef PIPELINE_RX_PARITY_EN
    logic perr_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            perr_q <= 1'b0;
        else if (push & (^{parity_in, data_in}))
            perr_q <= 1'b1;
    end
    assign parity_err = perr_q;
`endif

    assign valid_out  = (count_q != '0);
    assign data_out   = mem_q[rd_ptr_q];
    assign credit_out = credit_q;
    assign count      = count_q;
    assign overflow   = overflow_q;

endmodule
